spi_frame_ctrl: RTL and testbench

Master-side sequencer for the 8-bit LOAD/SCLK/MOSI/MISO shift-register slave port. It turns a single-cycle START request into one complete frame. The frame is a leading LOAD pulse (the slave parallel-loads its transmit byte), then 8 SCLK pulses exchanging one byte MSB-first, then a trailing LOAD pulse (the slave latches the received byte onto its DO). The block sits between the system clock domain and the slave, and generates every slave control signal from `clk`.

---
 rtl/spi_frame_ctrl_if.sv | 33 +++
 rtl/spi_frame_ctrl.sv | 139 +++++++++++++
 tb/tb_spi_frame_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_ctrl_if.sv
// spi_frame_ctrl_if: groups the frame request/result handshake and the four
// slave-port wires of the SPI frame sequencer.
//   START    frame request (system -> sequencer)
//   TX_DATA  byte to send on MOSI (system -> sequencer)
//   MISO     serial data from the shift-register slave
//   SCLK     serial clock to the slave, idles low
//   MOSI     serial data to the slave, MSB first
//   LOAD     slave load/latch strobe, active high
//   BUSY     frame in progress
//   DONE     one-cycle frame-complete pulse
//   RX_DATA  byte received on MISO, held until the next DONE
// Modports: master = system/bench side, slave = the sequencer itself.
interface spi_frame_ctrl_if;
    logic       START;
    logic [7:0] TX_DATA;
    logic       MISO;
    logic       SCLK;
    logic       MOSI;
    logic       LOAD;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RX_DATA;

    modport master (
        output START, TX_DATA, MISO,
        input  SCLK, MOSI, LOAD, BUSY, DONE, RX_DATA
    );

    modport slave (
        input  START, TX_DATA, MISO,
        output SCLK, MOSI, LOAD, BUSY, DONE, RX_DATA
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: master-side sequencer for an 8-bit LOAD/SCLK/MOSI/MISO
// shift-register slave. One accepted START produces a leading LOAD pulse,
// eight SCLK pulses exchanging one byte MSB first, a trailing LOAD pulse and
// a one-cycle DONE carrying the received byte on RX_DATA.
// Parameters: DIV (1..255) = SCLK half-period and LOAD pulse width in clk cycles.
// Ports: clk, rst (async, active high), bus (spi_frame_ctrl_if.slave).
// Optional feature: define SPI_FRAME_CTRL_LOOPBACK_EN to feed the block's own
// MOSI into the receive shifter instead of MISO (MISO is then ignored).
module spi_frame_ctrl #(
    parameter int unsigned DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_frame_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_LOW,
        S_HIGH,
        S_TAIL,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [7:0]       tx_sh;
    logic [7:0]       rx_sh;
    logic             last_c;
    logic             sample_c;

    // Final cycle of the current DIV-long phase.
    assign last_c = (cnt == CNT_LAST);

    // Receive source: own registered MOSI in loopback, else the slave's MISO.
`ifdef SPI_FRAME_CTRL_LOOPBACK_EN
    assign sample_c = bus.MOSI;
`else
    assign sample_c = bus.MISO;
`endif

    // Frame sequencer; every output is set on the edge that enters the state
    // it belongs to, so all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            bus.SCLK    <= 1'b0;
            bus.LOAD    <= 1'b0;
            bus.MOSI    <= 1'b0;
            bus.BUSY    <= 1'b0;
            bus.DONE    <= 1'b0;
            bus.RX_DATA <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        state    <= S_LEAD;
                        tx_sh    <= bus.TX_DATA;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        bus.LOAD <= 1'b1;
                        bus.BUSY <= 1'b1;
                    end
                end
                S_LEAD: begin
                    if (last_c) begin
                        state    <= S_LOW;
                        cnt      <= '0;
                        bus.LOAD <= 1'b0;
                        bus.MOSI <= tx_sh[7];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_LOW: begin
                    if (last_c) begin
                        state    <= S_HIGH;
                        cnt      <= '0;
                        bus.SCLK <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (last_c) begin
                        // Sample before the falling edge on which the slave shifts.
                        cnt      <= '0;
                        bus.SCLK <= 1'b0;
                        rx_sh    <= {rx_sh[6:0], sample_c};
                        if (bit_cnt == BIT_LAST) begin
                            state    <= S_TAIL;
                            bus.LOAD <= 1'b1;
                        end else begin
                            // Next bit goes out on the same edge that drops SCLK.
                            state    <= S_LOW;
                            tx_sh    <= {tx_sh[6:0], 1'b0};
                            bus.MOSI <= tx_sh[6];
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_TAIL: begin
                    if (last_c) begin
                        state       <= S_DONE;
                        cnt         <= '0;
                        bus.LOAD    <= 1'b0;
                        bus.DONE    <= 1'b1;
                        bus.RX_DATA <= rx_sh;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // START is not looked at here, so it cannot be queued.
                    state    <= S_IDLE;
                    bus.DONE <= 1'b0;
                    bus.BUSY <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed bench for spi_frame_ctrl with a DIV=4 instance
// (driving a behavioural shift-register slave) and a DIV=1 instance (MISO
// wired back to its own MOSI).
module tb_spi_frame_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_frame_ctrl_if b4();
    spi_frame_ctrl_if b1();

    spi_frame_ctrl #(.DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    spi_frame_ctrl #(.DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] pre);
`ifdef SPI_FRAME_CTRL_LOOPBACK_EN
        return tx;
`else
        return pre;
`endif
    endfunction

    // Behavioural slave: LOAD fall loads preload / latches DO, SCLK rise
    // samples MOSI, SCLK fall shifts. MISO is the shifter MSB.
    logic [7:0] sl_pre = 8'h3C;
    logic [7:0] sl_sh  = 8'h00;
    logic [7:0] sl_do  = 8'h00;
    logic       sl_bit = 1'b0;
    logic       sl_sclk_d = 1'b0;
    logic       sl_load_d = 1'b0;
    logic       tie1 = 1'b0;

    always @(b4.SCLK or b4.LOAD) begin
        if (!sl_sclk_d && b4.SCLK) sl_bit = b4.MOSI;
        if (sl_sclk_d && !b4.SCLK) sl_sh = {sl_sh[6:0], sl_bit};
        if (sl_load_d && !b4.LOAD) begin
            sl_do = sl_sh;
            sl_sh = sl_pre;
        end
        sl_sclk_d = b4.SCLK;
        sl_load_d = b4.LOAD;
    end

    assign b4.MISO = tie1 ? 1'b1 : sl_sh[7];
    assign b1.MISO = b1.MOSI;

    // Event counters and MOSI capture at every SCLK rise.
    logic [7:0] mosi_cap = 8'h00;
    int sclk_rises1 = 0;
    int done_cnt4 = 0;
    int done_cnt1 = 0;

    always @(posedge b4.SCLK) mosi_cap = {mosi_cap[6:0], b4.MOSI};
    always @(posedge b1.SCLK) sclk_rises1++;
    always @(posedge clk) begin
        if (b4.DONE) done_cnt4++;
        if (b1.DONE) done_cnt1++;
    end

    // Always-on protocol checks: no LOAD with SCLK, MOSI steady while SCLK high.
    logic prev_mosi4 = 1'b0;
    logic prev_mosi1 = 1'b0;
    always @(negedge clk) begin
        check("load_and_sclk_div4", 32'(b4.LOAD & b4.SCLK), 32'd0);
        check("load_and_sclk_div1", 32'(b1.LOAD & b1.SCLK), 32'd0);
        if (b4.SCLK) check("mosi_hold_div4", 32'(b4.MOSI), 32'(prev_mosi4));
        if (b1.SCLK) check("mosi_hold_div1", 32'(b1.MOSI), 32'(prev_mosi1));
        prev_mosi4 = b4.MOSI;
        prev_mosi1 = b1.MOSI;
    end

    // One DIV=4 frame; START re-pulsed at cycles p1..p3 (0 = none), early exit at abort_at.
    task automatic run_frame4(input logic [7:0] tx, input int p1, input int p2, input int p3,
                              input int abort_at, output int done_cyc, output int first_rise,
                              output logic load1, output logic busy_ok, output logic [7:0] rx);
        done_cyc   = -1;
        first_rise = -1;
        load1      = 1'b0;
        busy_ok    = 1'b1;
        rx         = 8'h00;
        @(negedge clk);
        b4.START   = 1'b1;
        b4.TX_DATA = tx;
        @(posedge clk);
        #1;
        b4.START   = 1'b0;
        b4.TX_DATA = ~tx;
        for (int cyc = 1; cyc < 200; cyc++) begin
            @(negedge clk);
            if (cyc == abort_at) return;
            if (cyc == 1) load1 = b4.LOAD;
            if (b4.SCLK && first_rise < 0) first_rise = cyc;
            b4.START = (cyc == p1) || (cyc == p2) || (cyc == p3);
            if (b4.DONE) begin
                done_cyc = cyc;
                rx       = b4.RX_DATA;
                break;
            end
            if (!b4.BUSY) busy_ok = 1'b0;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        b4.START = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         done_cyc;
        int         first_rise;
        logic       load1;
        logic       busy_ok;
        logic [7:0] rx;
        int         dc0;
        int         r0;
        int         d1;
        int         d2;
        logic [7:0] rx1;
        logic [7:0] rx2;

        b4.START = 1'b0;
        b4.TX_DATA = 8'h00;
        b1.START = 1'b0;
        b1.TX_DATA = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs_div4",
              32'({b4.SCLK, b4.LOAD, b4.MOSI, b4.BUSY, b4.DONE, b4.RX_DATA}), 32'd0);
        check("reset_outputs_div1",
              32'({b1.SCLK, b1.LOAD, b1.MOSI, b1.BUSY, b1.DONE, b1.RX_DATA}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic DIV=4 frame: A5 out, slave preload 3C back.
        dc0 = done_cnt4;
        run_frame4(8'hA5, 0, 0, 0, 0, done_cyc, first_rise, load1, busy_ok, rx);
        check("f1_done_cycle", 32'(done_cyc), 32'd73);
        check("f1_first_sclk_rise", 32'(first_rise), 32'd9);
        check("f1_load_at_cycle1", 32'(load1), 32'd1);
        check("f1_busy_held", 32'(busy_ok), 32'd1);
        check("f1_rx_data", 32'(rx), 32'(exp_rx(8'hA5, 8'h3C)));
        check("f1_mosi_bits", 32'(mosi_cap), 32'h0A5);
        @(negedge clk);
        check("f1_slave_do", 32'(sl_do), 32'h0A5);
        check("f1_busy_after", 32'({b4.BUSY, b4.DONE}), 32'd0);
        check("f1_done_count", 32'(done_cnt4 - dc0), 32'd1);

        // START re-pulsed mid-frame, in the last TAIL cycle and in DONE.
        dc0 = done_cnt4;
        run_frame4(8'h81, 10, 72, 73, 0, done_cyc, first_rise, load1, busy_ok, rx);
        check("f2_done_cycle", 32'(done_cyc), 32'd73);
        check("f2_busy_held", 32'(busy_ok), 32'd1);
        check("f2_rx_data", 32'(rx), 32'(exp_rx(8'h81, 8'h3C)));
        check("f2_mosi_bits", 32'(mosi_cap), 32'h081);
        repeat (80) @(negedge clk);
        check("f2_single_done", 32'(done_cnt4 - dc0), 32'd1);
        check("f2_idle_after", 32'(b4.BUSY), 32'd0);

        // DIV=1 back-to-back frames with START held high.
        r0 = sclk_rises1;
        dc0 = done_cnt1;
        d1 = -1;
        d2 = -1;
        rx1 = 8'h00;
        rx2 = 8'h00;
        @(negedge clk);
        b1.START = 1'b1;
        b1.TX_DATA = 8'hFF;
        @(posedge clk);
        #1;
        b1.TX_DATA = 8'h00;
        for (int cyc = 1; cyc < 100; cyc++) begin
            @(negedge clk);
            if (b1.DONE) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    rx1 = b1.RX_DATA;
                end else begin
                    d2 = cyc;
                    rx2 = b1.RX_DATA;
                    b1.START = 1'b0;
                    break;
                end
            end
            @(posedge clk);
        end
        b1.START = 1'b0;
        check("d1_first_done", 32'(d1), 32'd19);
        check("d1_second_done", 32'(d2), 32'd39);
        check("d1_rx_first", 32'(rx1), 32'h0FF);
        check("d1_rx_second", 32'(rx2), 32'h000);
        repeat (30) @(negedge clk);
        check("d1_sclk_pulses", 32'(sclk_rises1 - r0), 32'd16);
        check("d1_done_count", 32'(done_cnt1 - dc0), 32'd2);
        check("d1_idle_after", 32'(b1.BUSY), 32'd0);

        // Asynchronous reset at cycle 30 of a DIV=4 frame (bit 3 LOW phase, MOSI=1).
        run_frame4(8'h96, 0, 0, 0, 30, done_cyc, first_rise, load1, busy_ok, rx);
        check("r_pre_state", 32'({b4.SCLK, b4.LOAD, b4.MOSI, b4.BUSY}), 32'b0011);
        dc0 = done_cnt4;
        #2;
        rst = 1'b1;
        #1;
        check("r_async_outputs",
              32'({b4.SCLK, b4.LOAD, b4.MOSI, b4.BUSY, b4.DONE, b4.RX_DATA}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("r_no_done", 32'(done_cnt4 - dc0), 32'd0);
        sl_pre = 8'hC3;
        run_frame4(8'h5C, 0, 0, 0, 0, done_cyc, first_rise, load1, busy_ok, rx);
        check("r_new_done_cycle", 32'(done_cyc), 32'd73);
        check("r_new_rx_data", 32'(rx), 32'(exp_rx(8'h5C, 8'hC3)));
        check("r_new_mosi_bits", 32'(mosi_cap), 32'h05C);
        @(negedge clk);
        check("r_new_slave_do", 32'(sl_do), 32'h05C);

        // MISO tied high: loopback returns TX_DATA, otherwise all ones.
        tie1 = 1'b1;
        run_frame4(8'h5A, 0, 0, 0, 0, done_cyc, first_rise, load1, busy_ok, rx);
        check("t_done_cycle", 32'(done_cyc), 32'd73);
        check("t_rx_data", 32'(rx), 32'(exp_rx(8'h5A, 8'hFF)));
        tie1 = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
